// File: rtl/aucohl_adc_scan_seq.sv
// rtl/aucohl_adc_scan_seq.sv - multi-channel SAR ADC scan sequencer feeding a result FIFO
module aucohl_adc_scan_seq #(
    parameter int          SIZE   = 8,
    parameter int          NCH    = 8,
    parameter int          CW     = 3,
    parameter int          PW     = 16,
    parameter logic [3:0]  SETTLE = 4'd2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic                 cont,
    input  logic [NCH-1:0]       ch_mask,
    input  logic [PW-1:0]        period,
    output logic                 adc_soc,
    input  logic                 adc_eoc,
    input  logic [SIZE-1:0]      adc_data,
    output logic [CW-1:0]        adc_ch,
    output logic                 fifo_wr,
    output logic [CW+SIZE-1:0]   fifo_wdata,
    input  logic                 fifo_full,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    typedef enum logic [2:0] {IDLE, SEL, SOC, CONV, STORE, GAP} state_t;

    localparam logic [3:0] SETTLE_EFF = (SETTLE == 4'd0) ? 4'd1 : SETTLE;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [SIZE-1:0] hold_q, hold_d;
    logic [3:0]      settle_q, settle_d;
    logic [PW-1:0]   gap_q, gap_d;
    logic            ovf_q, ovf_d;

    logic            nxt_found;
    logic [CW-1:0]   nxt_ch;
    logic            is_store;

    function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [CW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = CW'(i);
        end
        return r;
    endfunction

    // Next higher channel of the latched mask, strictly above the current one.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (CW'(i) > ch_q)) begin
                nxt_found = 1'b1;
                nxt_ch    = CW'(i);
            end
        end
    end

    assign is_store   = en && (state_q == STORE);
    assign adc_soc    = en && (state_q == SOC);
    assign fifo_wr    = is_store && !fifo_full;
    assign fifo_wdata = fifo_wr ? {ch_q, hold_q} : '0;
    assign done       = is_store && !nxt_found;
    assign busy       = (state_q != IDLE);
    assign adc_ch     = ch_q;
    assign ovf        = ovf_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        mask_d   = mask_q;
        hold_d   = hold_q;
        settle_d = settle_q;
        gap_d    = gap_q;
        ovf_d    = ovf_q;

        if (ovf_clr) ovf_d = 1'b0;
        if (is_store && fifo_full) ovf_d = 1'b1;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && |ch_mask) begin
                        mask_d   = ch_mask;
                        ch_d     = lowest_set(ch_mask);
                        settle_d = SETTLE_EFF - 4'd1;
                        state_d  = SEL;
                    end
                end
                SEL: begin
                    if (settle_q == 4'd0) state_d = SOC;
                    else                  settle_d = settle_q - 4'd1;
                end
                SOC: state_d = CONV;
                CONV: begin
                    if (adc_eoc) begin
                        hold_d  = adc_data;
                        state_d = STORE;
                    end
                end
                STORE: begin
                    if (nxt_found) begin
                        ch_d     = nxt_ch;
                        settle_d = SETTLE_EFF - 4'd1;
                        state_d  = SEL;
                    end else if (cont) begin
                        gap_d   = period;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GAP: begin
                    // A period of 0 or 1 both give a single gap cycle.
                    if (gap_q <= PW'(1)) begin
                        if (|ch_mask) begin
                            mask_d   = ch_mask;
                            ch_d     = lowest_set(ch_mask);
                            settle_d = SETTLE_EFF - 4'd1;
                            state_d  = SEL;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_d = gap_q - PW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            mask_q   <= '0;
            hold_q   <= '0;
            settle_q <= '0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            mask_q   <= mask_d;
            hold_q   <= hold_d;
            settle_q <= settle_d;
            gap_q    <= gap_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_aucohl_adc_scan_seq.sv
// tb/tb_aucohl_adc_scan_seq.sv - bench for aucohl_adc_scan_seq with a SAR/FIFO model
module tb_aucohl_adc_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [15:0] period = 16'd0;
    logic        adc_soc;
    logic        adc_eoc = 1'b0;
    logic [7:0]  adc_data = 8'h00;
    logic [2:0]  adc_ch;
    logic        fifo_wr;
    logic [10:0] fifo_wdata;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    aucohl_adc_scan_seq dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont),
        .ch_mask(ch_mask), .period(period), .adc_soc(adc_soc), .adc_eoc(adc_eoc),
        .adc_data(adc_data), .adc_ch(adc_ch), .fifo_wr(fifo_wr),
        .fifo_wdata(fifo_wdata), .fifo_full(fifo_full), .busy(busy), .done(done),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int sar_cnt = 0;
    int full_cnt = 0;
    int eoc_idx = 0;
    int eoc_last = 0;
    int full_at = -1;
    int done_cnt = 0;
    int ovf_seen = 0;
    logic [10:0] wr_data[$];
    int          wr_cyc[$];
    int          soc_cyc[$];
    int          done_q[$];

    // Monitor plus SAR model: eoc 10 cycles after soc, data = ch*16+1.
    always @(negedge clk) begin
        cyc++;
        if (fifo_wr) begin
            wr_data.push_back(fifo_wdata);
            wr_cyc.push_back(cyc);
        end
        if (adc_soc) soc_cyc.push_back(cyc);
        if (done) begin
            done_cnt++;
            done_q.push_back(cyc);
        end
        if (ovf) ovf_seen++;
        if (full_cnt > 0) full_cnt--;
        adc_eoc = 1'b0;
        if (sar_cnt > 0) begin
            sar_cnt--;
            if (sar_cnt == 0) begin
                adc_eoc  = 1'b1;
                adc_data = 8'(int'(adc_ch) * 16 + 1);
                eoc_last = cyc;
                if (eoc_idx == full_at) full_cnt = 2;
                eoc_idx++;
            end
        end
        if (adc_soc) sar_cnt = 10;
        fifo_full = (full_cnt > 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check(name, {31'b0, busy}, 32'd0);
        tick(1);
    endtask

    task automatic wait_writes(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (wr_data.size() < target && k < budget) begin
            tick(1);
            k++;
        end
        check(name, {31'b0, wr_data.size() >= target}, 32'd1);
    endtask

    task automatic wait_socs(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (soc_cyc.size() < target && k < budget) begin
            tick(1);
            k++;
        end
        check(name, {31'b0, soc_cyc.size() >= target}, 32'd1);
    endtask

    function automatic logic [10:0] exp_word(input int ch);
        logic [2:0] c;
        logic [7:0] d;
        c = 3'(ch);
        d = 8'(ch * 16 + 1);
        return {c, d};
    endfunction

    typedef struct packed {
        logic [7:0]        mask;
        logic signed [7:0] full_idx;
        logic              clr;
        logic [3:0]        n;
        logic [31:0]       chs;
        logic              ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int s, base, d0, sb, db, n, ch, m;

        vecs[0] = '{mask: 8'h85, full_idx: -8'sd1, clr: 1'b0, n: 4'd3, chs: 32'h0000_0720, ovf: 1'b0};
        vecs[1] = '{mask: 8'h85, full_idx:  8'sd1, clr: 1'b0, n: 4'd2, chs: 32'h0000_0070, ovf: 1'b1};
        vecs[2] = '{mask: 8'h80, full_idx: -8'sd1, clr: 1'b0, n: 4'd1, chs: 32'h0000_0007, ovf: 1'b1};
        vecs[3] = '{mask: 8'h01, full_idx: -8'sd1, clr: 1'b1, n: 4'd1, chs: 32'h0000_0000, ovf: 1'b0};
        vecs[4] = '{mask: 8'hFF, full_idx:  8'sd0, clr: 1'b0, n: 4'd7, chs: 32'h0765_4321, ovf: 1'b1};
        vecs[5] = '{mask: 8'h12, full_idx: -8'sd1, clr: 1'b0, n: 4'd2, chs: 32'h0000_0041, ovf: 1'b1};

        tick(2);
        check("reset_outputs", {13'b0, adc_soc, adc_ch, fifo_wr, fifo_wdata, busy, done, ovf}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Latency: soc in cycle 3, eoc in cycle 13, fifo_wr in cycle 14.
        ch_mask = 8'h01;
        sb = soc_cyc.size();
        base = wr_data.size();
        do_start(s);
        check("lat_busy_c1", {31'b0, busy}, 32'd1);
        wait_idle("lat_idle", 100);
        check("lat_soc_count", soc_cyc.size() - sb, 32'd1);
        if (soc_cyc.size() > sb) check("lat_soc_cycle", soc_cyc[sb] - s, 32'd3);
        check("lat_eoc_cycle", eoc_last - s, 32'd13);
        if (wr_data.size() > base) check("lat_wr_cycle", wr_cyc[base] - s, 32'd14);

        foreach (vecs[v]) begin
            if (vecs[v].clr) begin
                ovf_clr = 1'b1;
                tick(1);
                ovf_clr = 1'b0;
            end
            full_at = (vecs[v].full_idx < 0) ? -1 : eoc_idx + int'(vecs[v].full_idx);
            base = wr_data.size();
            d0 = done_cnt;
            ch_mask = vecs[v].mask;
            cont = 1'b0;
            do_start(s);
            ch_mask = ~vecs[v].mask;
            wait_idle($sformatf("v%0d_idle", v), 300);
            full_at = -1;
            n = wr_data.size() - base;
            check($sformatf("v%0d_count", v), n, {28'b0, vecs[v].n});
            for (int i = 0; i < n && i < int'(vecs[v].n); i++) begin
                ch = int'((vecs[v].chs >> (4 * i)) & 32'hF);
                check($sformatf("v%0d_w%0d", v, i), {21'b0, wr_data[base + i]}, {21'b0, exp_word(ch)});
            end
            check($sformatf("v%0d_done", v), done_cnt - d0, 32'd1);
            if (n > 0 && done_q.size() > 0)
                check($sformatf("v%0d_done_at_last", v), done_q[done_q.size() - 1], wr_cyc[wr_cyc.size() - 1]);
            check($sformatf("v%0d_ovf", v), {31'b0, ovf}, {31'b0, vecs[v].ovf});
        end

        // Async reset while in SEL clears everything, including the sticky ovf.
        ch_mask = 8'h04;
        do_start(s);
        check("rst_pre_state", {28'b0, busy, adc_ch}, {28'b0, 1'b1, 3'd2});
        rst_n = 1'b0;
        #1;
        check("rst_mid_sel", {13'b0, adc_soc, adc_ch, fifo_wr, fifo_wdata, busy, done, ovf}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // A drop with ovf_clr held high still raises ovf for a cycle.
        ch_mask = 8'h01;
        ovf_clr = 1'b1;
        full_at = eoc_idx;
        m = ovf_seen;
        base = wr_data.size();
        do_start(s);
        wait_idle("setwin_idle", 100);
        full_at = -1;
        ovf_clr = 1'b0;
        check("setwin_seen", {31'b0, ovf_seen != m}, 32'd1);
        check("setwin_nowrite", wr_data.size() - base, 32'd0);
        check("setwin_cleared", {31'b0, ovf}, 32'd0);

        // Abort in CONV: back to IDLE next cycle, late eoc is ignored.
        ch_mask = 8'h20;
        sb = soc_cyc.size();
        base = wr_data.size();
        do_start(s);
        wait_socs("abort_soc", sb + 1, 50);
        en = 1'b0;
        tick(1);
        check("abort_idle", {31'b0, busy}, 32'd0);
        check("abort_ch_hold", {29'b0, adc_ch}, 32'd5);
        en = 1'b1;
        tick(15);
        check("abort_nowrite", wr_data.size() - base, 32'd0);
        check("abort_still_idle", {31'b0, busy}, 32'd0);

        // Continuous scan, period 5, then cont dropped during the second scan.
        ch_mask = 8'h03;
        cont = 1'b1;
        period = 16'd5;
        base = wr_data.size();
        d0 = done_cnt;
        db = done_q.size();
        sb = soc_cyc.size();
        do_start(s);
        wait_writes("cont_3writes", base + 3, 200);
        cont = 1'b0;
        wait_idle("cont_idle", 200);
        check("cont_count", wr_data.size() - base, 32'd4);
        for (int i = 0; i < 4 && base + i < wr_data.size(); i++)
            check($sformatf("cont_w%0d", i), {21'b0, wr_data[base + i]}, {21'b0, exp_word(i % 2)});
        check("cont_done", done_cnt - d0, 32'd2);
        if (soc_cyc.size() > sb + 2 && done_q.size() > db)
            check("cont_gap", soc_cyc[sb + 2] - done_q[db], 32'd8);

        // period=0: a single gap cycle.
        ch_mask = 8'h80;
        cont = 1'b1;
        period = 16'd0;
        base = wr_data.size();
        db = done_q.size();
        sb = soc_cyc.size();
        do_start(s);
        wait_socs("p0_second_soc", sb + 2, 100);
        cont = 1'b0;
        wait_idle("p0_idle", 100);
        check("p0_count", wr_data.size() - base, 32'd2);
        if (wr_data.size() > base + 1)
            check("p0_w1", {21'b0, wr_data[base + 1]}, {21'b0, exp_word(7)});
        if (soc_cyc.size() > sb + 1 && done_q.size() > db)
            check("p0_gap", soc_cyc[sb + 1] - done_q[db], 32'd4);

        // Empty mask: start is ignored.
        ch_mask = 8'h00;
        sb = soc_cyc.size();
        do_start(s);
        tick(3);
        check("mask0_idle", {31'b0, busy}, 32'd0);
        check("mask0_nosoc", soc_cyc.size() - sb, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
